// File: rtl/shifter_right_seq.sv
// Multi-cycle 32-bit right shifter: one shared stage applies the 16/8/4/2/1
// shift steps on successive clocks, with logical or arithmetic fill.

module shifter_right_stage (
  input  logic [31:0] i_work,
  input  logic [2:0]  i_k,
  input  logic        i_en,
  input  logic        i_fill,
  output logic [31:0] o_work
);
  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = i_work;
    case (i_k)
      3'd4:    w_shifted = {{16{i_fill}}, i_work[31:16]};
      3'd3:    w_shifted = {{8{i_fill}},  i_work[31:8]};
      3'd2:    w_shifted = {{4{i_fill}},  i_work[31:4]};
      3'd1:    w_shifted = {{2{i_fill}},  i_work[31:2]};
      3'd0:    w_shifted = {i_fill,       i_work[31:1]};
      default: w_shifted = i_work;
    endcase
    o_work = i_en ? w_shifted : i_work;
  end
endmodule

module shifter_right_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data,
  input  logic [31:0] control,
  input  logic        arith,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      r_state;
  logic [31:0] r_work;
  logic [4:0]  r_amt;
  logic        r_fill;
  logic [2:0]  r_k;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_dataOut;
  logic [31:0] w_stage;
  logic        w_en;

  // r_k only ever holds 0..4, so it always selects a valid amount bit.
  assign w_en = r_amt[r_k];

  shifter_right_stage u_stage (
    .i_work (r_work),
    .i_k    (r_k),
    .i_en   (w_en),
    .i_fill (r_fill),
    .o_work (w_stage)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_amt     <= '0;
      r_fill    <= 1'b0;
      r_k       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dataOut <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work  <= data;
            r_amt   <= control[4:0];
            r_fill  <= arith & data[31];
            r_k     <= 3'd4;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_work <= w_stage;
          if (r_k == 3'd0) begin
            r_dataOut <= w_stage;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_k <= r_k - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign dataOut = r_dataOut;
endmodule

// File: tb/tb_shifter_right_seq.sv
// Directed bench for shifter_right_seq: per-scenario tasks with inline checks.

module tb_shifter_right_seq;
  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data;
  logic [31:0] control;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;

  shifter_right_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data    (data),
    .control (control),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full operation with per-cycle checks of busy/done timing.
  task automatic run_op(input logic [31:0] d, input logic [31:0] c, input logic a,
                        input logic [31:0] exp, input string nm);
    @(negedge clk);
    data = d; control = c; arith = a; start = 1'b1;
    @(negedge clk);  // after acceptance edge E0
    start = 1'b0; data = ~d; control = 32'h0000_0013; arith = ~a;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", nm, busy, done);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL %s stage%0d: busy=%b done=%b required busy=1 done=0", nm, i, busy, done);
      end
    end
    @(negedge clk);  // after E5
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || dataOut !== exp) begin
      errors++;
      $display("FAIL %s result: done=%b busy=%b dataOut=%h required done=1 busy=0 dataOut=%h",
               nm, done, busy, dataOut, exp);
    end
    @(negedge clk);  // after E6
    checks++;
    if (done !== 1'b0 || dataOut !== exp) begin
      errors++; $display("FAIL %s hold: done=%b dataOut=%h required done=0 dataOut=%h", nm, done, dataOut, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data = 32'hDEAD_BEEF; control = 32'd3; arith = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 32'h0) begin
      errors++; $display("FAIL reset: busy=%b done=%b dataOut=%h required 0 0 00000000", busy, done, dataOut);
    end
    reset = 1'b0;
  endtask

  task automatic test_logical();
    run_op(32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001, "srl31");
    run_op(32'h8765_4321, 32'd8,  1'b0, 32'h0087_6543, "srl8");
  endtask

  task automatic test_arith();
    run_op(32'h8765_4321, 32'd8,  1'b1, 32'hFF87_6543, "sra8");
    run_op(32'h7000_0000, 32'd4,  1'b1, 32'h0700_0000, "sra_pos");
    run_op(32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF, "sra31");
  endtask

  task automatic test_amount();
    run_op(32'h1234_5678, 32'hFFFF_FFE0, 1'b0, 32'h1234_5678, "amt0_upper");
    run_op(32'h1234_5678, 32'd16,        1'b0, 32'h0000_1234, "amt16");
    run_op(32'hF234_5678, 32'd21,        1'b1, 32'hFFFF_FF91, "amt21");
  endtask

  task automatic test_start_while_busy();
    int ndone;
    @(negedge clk);
    data = 32'h0000_FF00; control = 32'd4; arith = 1'b0; start = 1'b1;
    @(negedge clk);  // after E0
    start = 1'b0;
    @(negedge clk);  // after E1: second request is seen at E2
    data = 32'hFFFF_FFFF; control = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (dataOut !== 32'h0000_0FF0) begin
          errors++; $display("FAIL busy_start value: dataOut=%h required 00000ff0", dataOut);
        end
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL busy_start count: done pulses=%0d required 1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    data = 32'hF0F0_F0F0; control = 32'd4; arith = 1'b1; start = 1'b1;
    @(negedge clk);  // after E0
    start = 1'b0;
    @(negedge clk);  // after E1
    @(negedge clk);  // after E2
    reset = 1'b1;
    @(negedge clk);  // after E3, reset sampled
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 32'h0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b dataOut=%h required 0 0 00000000", busy, done, dataOut);
    end
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL reset_mid done: pulses=%0d required 0", ndone);
    end
  endtask

  // start held high; each op is accepted on the edge ending the previous
  // done cycle, so results arrive every 6 falling edges.
  task automatic test_back_to_back();
    logic [31:0] d_v [3] = '{32'hF000_0000, 32'h0000_0100, 32'h8000_0000};
    logic [31:0] c_v [3] = '{32'd4,         32'd8,         32'd1};
    logic        a_v [3] = '{1'b1,          1'b0,          1'b1};
    logic [31:0] e_v [3] = '{32'hFF00_0000, 32'h0000_0001, 32'hC000_0000};
    int cyc, last, waited;
    @(negedge clk);
    data = d_v[0]; control = c_v[0]; arith = a_v[0]; start = 1'b1;
    cyc = 0; last = 0;
    for (int j = 0; j < 3; j++) begin
      waited = 0;
      do begin
        @(negedge clk); cyc++; waited++;
      end while (done !== 1'b1 && waited < 20);
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL b2b%0d timeout: no done within 20 cycles", j);
      end else begin
        if (dataOut !== e_v[j]) begin
          errors++; $display("FAIL b2b%0d value: dataOut=%h required %h", j, dataOut, e_v[j]);
        end
        checks++;
        if (cyc - last != 6) begin
          errors++; $display("FAIL b2b%0d spacing: %0d cycles required 6", j, cyc - last);
        end
      end
      last = cyc;
      if (j < 2) begin
        data = d_v[j+1]; control = c_v[j+1]; arith = a_v[j+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dataOut !== e_v[2]) begin
      errors++; $display("FAIL b2b drain: busy=%b dataOut=%h required 0 %h", busy, dataOut, e_v[2]);
    end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_amount();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
